wb_arbiter2: RTL and testbench
==============================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width on all ports.
REQ-002 SHALL have parameter TIMEOUT, default 255, stall cycles before a forced error (range 1..65535).
REQ-003 SHALL have port sys_clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have master port 0 (slave-side inputs from CPU): m0_cyc, m0_stb, m0_we in 1; m0_sel in 4; m0_adr in ADDR_WIDTH; m0_mosi in 32; m0_miso out 32; m0_ack, m0_err out 1.
REQ-006 SHALL have master port 1 (e.g. loader/DMA), signals identical to REQ-005 with prefix m1_.
REQ-007 SHALL have downstream port to one Wishbone slave (BRAM): s_cyc, s_stb, s_we out 1; s_sel out 4; s_adr out ADDR_WIDTH; s_mosi out 32; s_miso in 32; s_ack, s_err in 1.

Function
REQ-008 SHALL implement FSM states IDLE, OWN0, OWN1; reset state IDLE.
REQ-009 In IDLE with exactly one mN_cyc high, SHALL enter OWNN next cycle.
REQ-010 In IDLE with both cyc high, SHALL grant the master not granted last (register last_grant, reset value 1, so m0 wins first).
REQ-011 SHALL update last_grant on every entry into OWN0/OWN1.
REQ-012 In OWNN, SHALL drive s_cyc/s_stb/s_we/s_sel/s_adr/s_mosi from master N combinationally; in IDLE all s_* outputs SHALL be 0.
REQ-013 In OWNN, SHALL route s_miso/s_ack/s_err to master N only; other master sees miso=0, ack=0, err=0.
REQ-014 Arbitration latency SHALL be exactly one cycle (request in cycle t, s_cyc high in t+1); no added latency on ack path.
REQ-015 SHALL hold grant while owner's cyc is high (bus lock across multiple stb phases).
REQ-016 SHALL return OWNN -> IDLE on the cycle after mN_cyc falls; s_cyc/s_stb are 0 in IDLE, guaranteeing the slave sees at least one idle cycle between owners.
REQ-017 No direct OWN0 -> OWN1 transition; every handover passes through IDLE.
REQ-018 Non-owner requests SHALL wait without ack/err; inputs are ignored until granted.

Reset
REQ-019 sys_rst low SHALL asynchronously force IDLE, last_grant=1, timeout counter=0, all s_* outputs and mN_ack/mN_err/mN_miso to 0.
REQ-020 Reset asserted mid-transaction SHALL abandon it; no ack/err issued for it after release.

Configuration
REQ-021 Macro WB_ARBITER2_TIMEOUT_EN defined: 16-bit counter increments each cycle in OWNN with s_cyc&s_stb high and s_ack,s_err low; cleared on ack/err, on IDLE, and on reset.
REQ-022 With WB_ARBITER2_TIMEOUT_EN, counter reaching TIMEOUT SHALL pulse mN_err for one cycle, force s_cyc/s_stb low, and return to IDLE; counter then 0.
REQ-023 Without WB_ARBITER2_TIMEOUT_EN, no counter exists; err solely passes through from s_err; TIMEOUT ignored.

Structure
REQ-024 FSM state enum and default TIMEOUT constant SHALL live in shared package wb_pkg alongside the WISHBONE port macros.
REQ-025 No sub-module; the single-slave mux is inline (a wb_mux sub-module is not justified for one slave).

Verification
REQ-026 m0 alone writes 0xDEADBEEF to adr 0x10, sel 0xF -> s_cyc high one cycle after m0_cyc, m0_ack one cycle later; m1_ack stays 0.
REQ-027 m0 and m1 raise cyc in same cycle after reset -> m0 granted; m1 granted only after m0_cyc drops plus one IDLE cycle.
REQ-028 Both request continuously, one transfer each per cyc -> grants alternate m0,m1,m0,m1 over 4 transactions.
REQ-029 m1 locks cyc across 3 reads (adr 0x0,0x4,0x8) while m0 requests -> m0 stalls until m1_cyc falls; data 0x0/0x4/0x8 read back matches prior writes.
REQ-030 sys_rst pulsed low during OWN1 with stb high -> all outputs 0 same cycle; after release FSM IDLE, no stray m1_ack.
REQ-031 WB_ARBITER2_TIMEOUT_EN, TIMEOUT=4, slave model never acks -> m0_err high exactly on 5th stall cycle, s_cyc low next cycle, FSM IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus-width macros, arbiter state encoding,
// default stall timeout and the round-robin pick helper.
`ifndef WB_PKG_SV
`define WB_PKG_SV

`define WB_DAT_W 32
`define WB_SEL_W 4

package wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

   localparam int unsigned WB_TIMEOUT_DEFAULT = 32'd255;

   // A sole requester always wins; on a tie the master not served last wins.
   function automatic arb_state_e arb_pick(input logic cyc0, input logic cyc1,
                                           input logic last_grant);
      arb_state_e pick;
      if (cyc0 && cyc1) begin
         pick = last_grant ? ST_OWN0 : ST_OWN1;
      end else if (cyc0) begin
         pick = ST_OWN0;
      end else if (cyc1) begin
         pick = ST_OWN1;
      end else begin
         pick = ST_IDLE;
      end
      return pick;
   endfunction

endpackage

`endif

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie break and bus lock.
// Define WB_ARBITER2_TIMEOUT_EN to add a stall watchdog that errors a hung slave.
module wb_arbiter2
   import wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32'd32,
   parameter int unsigned TIMEOUT    = WB_TIMEOUT_DEFAULT
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  m0_cyc,
   input  logic                  m0_stb,
   input  logic                  m0_we,
   input  logic [3:0]            m0_sel,
   input  logic [ADDR_WIDTH-1:0] m0_adr,
   input  logic [31:0]           m0_mosi,
   output logic [31:0]           m0_miso,
   output logic                  m0_ack,
   output logic                  m0_err,
   input  logic                  m1_cyc,
   input  logic                  m1_stb,
   input  logic                  m1_we,
   input  logic [3:0]            m1_sel,
   input  logic [ADDR_WIDTH-1:0] m1_adr,
   input  logic [31:0]           m1_mosi,
   output logic [31:0]           m1_miso,
   output logic                  m1_ack,
   output logic                  m1_err,
   output logic                  s_cyc,
   output logic                  s_stb,
   output logic                  s_we,
   output logic [3:0]            s_sel,
   output logic [ADDR_WIDTH-1:0] s_adr,
   output logic [31:0]           s_mosi,
   input  logic [31:0]           s_miso,
   input  logic                  s_ack,
   input  logic                  s_err
);

   arb_state_e state_r;
   logic       last_grant_r;
   arb_state_e pick_s;
   logic       timeout_s;

   if (TIMEOUT < 32'd1 || TIMEOUT > 32'd65535) begin : g_timeout_range
      $error("wb_arbiter2: TIMEOUT must lie in 1..65535");
   end

   assign pick_s = arb_pick(m0_cyc, m1_cyc, last_grant_r);

   // Ownership FSM: every handover passes through IDLE so the slave sees an idle cycle.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r <= pick_s;
               if (pick_s == ST_OWN0) begin
                  last_grant_r <= 1'b0;
               end else if (pick_s == ST_OWN1) begin
                  last_grant_r <= 1'b1;
               end else begin
                  last_grant_r <= last_grant_r;
               end
            end
            ST_OWN0: state_r <= (!m0_cyc || timeout_s) ? ST_IDLE : ST_OWN0;
            ST_OWN1: state_r <= (!m1_cyc || timeout_s) ? ST_IDLE : ST_OWN1;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

`ifdef WB_ARBITER2_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   logic [15:0] to_cnt_r;
   logic        stall_s;

   // Stall is judged from the owner's own inputs so the watchdog never feeds back through the mux.
   assign stall_s = ((state_r == ST_OWN0) && m0_cyc && m0_stb && !s_ack && !s_err) ||
                    ((state_r == ST_OWN1) && m1_cyc && m1_stb && !s_ack && !s_err);
   assign timeout_s = stall_s && (to_cnt_r == TIMEOUT_C);

   // Counts consecutive stalled cycles of the current owner.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         to_cnt_r <= 16'd0;
      end else if ((state_r == ST_IDLE) || !stall_s || timeout_s) begin
         to_cnt_r <= 16'd0;
      end else begin
         to_cnt_r <= to_cnt_r + 16'd1;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Inline slave mux: the owner drives the slave and alone sees its responses.
   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_sel   = 4'd0;
      s_adr   = {ADDR_WIDTH{1'b0}};
      s_mosi  = 32'd0;
      m0_miso = 32'd0;
      m0_ack  = 1'b0;
      m0_err  = 1'b0;
      m1_miso = 32'd0;
      m1_ack  = 1'b0;
      m1_err  = 1'b0;
      case (state_r)
         ST_OWN0: begin
            s_cyc   = m0_cyc;
            s_stb   = m0_stb;
            s_we    = m0_we;
            s_sel   = m0_sel;
            s_adr   = m0_adr;
            s_mosi  = m0_mosi;
            m0_miso = s_miso;
            m0_ack  = s_ack;
            m0_err  = s_err | timeout_s;
         end
         ST_OWN1: begin
            s_cyc   = m1_cyc;
            s_stb   = m1_stb;
            s_we    = m1_we;
            s_sel   = m1_sel;
            s_adr   = m1_adr;
            s_mosi  = m1_mosi;
            m1_miso = s_miso;
            m1_ack  = s_ack;
            m1_err  = s_err | timeout_s;
         end
         default: begin
            s_cyc = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Randomized self-checking bench for wb_arbiter2 with a transaction-level
// ownership/memory reference model and directed arbitration scenarios.
module tb_wb_arbiter2;

   localparam int AW = 32;
`ifdef WB_ARBITER2_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b0;

   logic          m_cyc  [2];
   logic          m_stb  [2];
   logic          m_we   [2];
   logic [3:0]    m_sel  [2];
   logic [AW-1:0] m_adr  [2];
   logic [31:0]   m_mosi [2];
   logic [31:0]   m_miso [2];
   logic          m_ack  [2];
   logic          m_err  [2];

   logic          s_cyc, s_stb, s_we;
   logic [3:0]    s_sel;
   logic [AW-1:0] s_adr;
   logic [31:0]   s_mosi;
   logic [31:0]   s_miso = 32'd0;
   logic          s_ack  = 1'b0;
   logic          s_err  = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_cnt  = 0;
   int grant_log[$];
   bit mon_en     = 1'b0;
   bit slave_mute = 1'b0;

   logic [31:0] mem     [256] = '{default: 32'd0};
   logic [31:0] ref_mem [256] = '{default: 32'd0};
   int who  = -1;
   int last = 1;

   wb_arbiter2 #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_sel(m_sel[0]),
      .m0_adr(m_adr[0]), .m0_mosi(m_mosi[0]), .m0_miso(m_miso[0]),
      .m0_ack(m_ack[0]), .m0_err(m_err[0]),
      .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_sel(m_sel[1]),
      .m1_adr(m_adr[1]), .m1_mosi(m_mosi[1]), .m1_miso(m_miso[1]),
      .m1_ack(m_ack[1]), .m1_err(m_err[1]),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
      .s_mosi(s_mosi), .s_miso(s_miso), .s_ack(s_ack), .s_err(s_err)
   );

   always #5 sys_clk = ~sys_clk;

   // Cycle counter used to timestamp acknowledges.
   always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
      end
   endtask

   // BRAM model: registered single-cycle ack, word 255 answers with err, can be muted.
   always @(posedge sys_clk) begin
      if (s_cyc && s_stb && !s_ack && !s_err && !slave_mute) begin
         if (s_adr[9:2] == 8'hFF) begin
            s_err <= 1'b1;
         end else begin
            s_ack  <= 1'b1;
            s_miso <= mem[s_adr[9:2]];
            if (s_we) mem[s_adr[9:2]] <= s_mosi;
         end
      end else begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
      end
   end

   // Reference owner: -1 means nobody; ties go to the master not served last.
   function automatic int next_who(int w, logic c0, logic c1, int l);
      if (w == -1) begin
         if (c0 && c1) return 1 - l;
         if (c0) return 0;
         if (c1) return 1;
         return -1;
      end
      if (w == 0) return c0 ? 0 : -1;
      return c1 ? 1 : -1;
   endfunction

   always @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         who  <= -1;
         last <= 1;
      end else begin
         who <= next_who(who, m_cyc[0], m_cyc[1], last);
         if (who == -1 && next_who(who, m_cyc[0], m_cyc[1], last) != -1)
            last <= next_who(who, m_cyc[0], m_cyc[1], last);
      end
   end

   // Per-cycle monitor: slave-side mux, response routing and read data versus memory model.
   always @(negedge sys_clk) begin : mon
      logic          ec, es, ew;
      logic [3:0]    esel;
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      if (mon_en && sys_rst) begin
         if (who >= 0) begin
            ec = m_cyc[who]; es = m_stb[who]; ew = m_we[who];
            esel = m_sel[who]; ea = m_adr[who]; ed = m_mosi[who];
         end else begin
            ec = 1'b0; es = 1'b0; ew = 1'b0; esel = 4'd0; ea = '0; ed = 32'd0;
         end
         chk_eq("s_cyc", 64'(s_cyc), 64'(ec));
         chk_eq("s_stb", 64'(s_stb), 64'(es));
         chk_eq("s_we", 64'(s_we), 64'(ew));
         chk_eq("s_sel", 64'(s_sel), 64'(esel));
         chk_eq("s_adr", 64'(s_adr), 64'(ea));
         chk_eq("s_mosi", 64'(s_mosi), 64'(ed));
         for (int i = 0; i < 2; i++) begin
            chk_eq($sformatf("m%0d_ack", i), 64'(m_ack[i]), 64'((who == i) && s_ack));
            chk_eq($sformatf("m%0d_err", i), 64'(m_err[i]), 64'((who == i) && s_err));
            if (who != i) chk_eq($sformatf("m%0d_miso_idle", i), 64'(m_miso[i]), 64'd0);
         end
         if (who >= 0 && s_ack) begin
            if (m_we[who]) ref_mem[m_adr[who][9:2]] <= m_mosi[who];
            else chk_eq("rdata", 64'(m_miso[who]), 64'(ref_mem[m_adr[who][9:2]]));
         end
      end
   end

   task automatic wb_xfer(input int id, input logic we, input logic [7:0] idx,
                          input logic [31:0] wdat, input bit keep,
                          output logic [31:0] rdat, output int ack_cyc);
      int n;
      @(posedge sys_clk); #1;
      m_cyc[id] = 1'b1; m_stb[id] = 1'b1; m_we[id] = we; m_sel[id] = 4'hF;
      m_adr[id] = AW'({idx, 2'b00}); m_mosi[id] = wdat;
      n = 0;
      while (n < 200) begin
         @(negedge sys_clk);
         if (m_ack[id] || m_err[id]) break;
         n++;
      end
      chk_eq($sformatf("m%0d_xfer_done", id), 64'(m_ack[id] | m_err[id]), 64'd1);
      rdat = m_miso[id];
      ack_cyc = cyc_cnt;
      grant_log.push_back(id);
      @(posedge sys_clk); #1;
      m_stb[id] = 1'b0;
      if (!keep) m_cyc[id] = 1'b0;
   endtask

   task automatic rand_master(input int id, input int n);
      int gap, blen, ac;
      logic [7:0] idx;
      logic [31:0] rd;
      for (int t = 0; t < n; t++) begin
         gap = int'($urandom_range(0, 3));
         repeat (gap) @(posedge sys_clk);
         blen = int'($urandom_range(1, 3));
         for (int b = 0; b < blen; b++) begin
            idx = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            wb_xfer(id, 1'($urandom_range(0, 1)), idx, $urandom, b < blen - 1, rd, ac);
         end
      end
   endtask

   task automatic do_reset();
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] rd, rd0, rd1, rd2, wv[3];
      int ac0, ac1, acm0, acm1, stall;
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = 1'b1; m_sel[i] = 4'hF;
         m_adr[i] = AW'(32'h40); m_mosi[i] = 32'h1234_5678;
      end
      // Outputs stay quiet under reset even with both masters requesting.
      repeat (2) @(negedge sys_clk);
      chk_eq("rst_s_cyc", 64'(s_cyc), 64'd0);
      chk_eq("rst_s_adr", 64'(s_adr), 64'd0);
      chk_eq("rst_m0_ack", 64'(m_ack[0]), 64'd0);
      chk_eq("rst_m1_miso", 64'(m_miso[1]), 64'd0);
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      end
      @(posedge sys_clk); #1 sys_rst = 1'b1;
      mon_en = 1'b1;

      // m0 alone writes DEADBEEF to 0x10.
      @(posedge sys_clk); #1;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_sel[0] = 4'hF;
      m_adr[0] = AW'(32'h10); m_mosi[0] = 32'hDEAD_BEEF;
      @(negedge sys_clk);
      chk_eq("r26_req_cycle_s_cyc", 64'(s_cyc), 64'd0);
      @(negedge sys_clk);
      chk_eq("r26_grant_s_cyc", 64'(s_cyc), 64'd1);
      chk_eq("r26_s_adr", 64'(s_adr), 64'h10);
      chk_eq("r26_no_early_ack", 64'(m_ack[0]), 64'd0);
      @(negedge sys_clk);
      chk_eq("r26_m0_ack", 64'(m_ack[0]), 64'd1);
      chk_eq("r26_m1_ack", 64'(m_ack[1]), 64'd0);
      @(posedge sys_clk); #1;
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
      wb_xfer(0, 1'b0, 8'd4, 32'd0, 1'b0, rd, ac0);
      chk_eq("r26_readback", 64'(rd), 64'hDEAD_BEEF);

      // Simultaneous request right after reset: m0 first, m1 after drop plus one idle cycle.
      do_reset();
      fork
         wb_xfer(0, 1'b1, 8'd1, 32'h0000_0A01, 1'b0, rd0, ac0);
         wb_xfer(1, 1'b1, 8'd2, 32'h0000_0B02, 1'b0, rd1, ac1);
      join
      chk_eq("r27_m0_first", 64'(ac0 < ac1), 64'd1);
      chk_eq("r27_gap", 64'(ac1 - ac0), 64'd4);

      // Continuous requests alternate grants.
      grant_log.delete();
      fork
         begin
            wb_xfer(0, 1'b1, 8'd5, 32'h5555_0000, 1'b0, rd, ac0);
            wb_xfer(0, 1'b1, 8'd6, 32'h6666_0000, 1'b0, rd, ac0);
         end
         begin
            wb_xfer(1, 1'b1, 8'd7, 32'h7777_0000, 1'b0, rd1, ac1);
            wb_xfer(1, 1'b1, 8'd8, 32'h8888_0000, 1'b0, rd1, ac1);
         end
      join
      chk_eq("r28_count", 64'(grant_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         chk_eq($sformatf("r28_order%0d", i), 64'(grant_log[i]), 64'(i % 2));

      // m1 locks the bus across three reads while m0 waits.
      for (int i = 0; i < 3; i++) begin
         wv[i] = $urandom;
         wb_xfer(0, 1'b1, 8'(i), wv[i], 1'b0, rd, ac0);
      end
      fork
         begin
            wb_xfer(1, 1'b0, 8'd0, 32'd0, 1'b1, rd0, ac1);
            wb_xfer(1, 1'b0, 8'd1, 32'd0, 1'b1, rd1, ac1);
            wb_xfer(1, 1'b0, 8'd2, 32'd0, 1'b0, rd2, acm1);
         end
         begin
            @(posedge sys_clk);
            wb_xfer(0, 1'b1, 8'd9, 32'h0909_0909, 1'b0, rd, acm0);
         end
      join
      chk_eq("r29_rd0", 64'(rd0), 64'(wv[0]));
      chk_eq("r29_rd4", 64'(rd1), 64'(wv[1]));
      chk_eq("r29_rd8", 64'(rd2), 64'(wv[2]));
      chk_eq("r29_m0_waits", 64'(acm0 > acm1), 64'd1);

      // Reset pulse while m1 owns the bus with stb high.
      slave_mute = 1'b1;
      @(posedge sys_clk); #1;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = AW'(32'h8);
      for (int n = 0; n < 10 && !s_cyc; n++) @(negedge sys_clk);
      chk_eq("r30_granted", 64'(s_cyc), 64'd1);
      #1 sys_rst = 1'b0;
      #1;
      chk_eq("r30_s_cyc", 64'(s_cyc), 64'd0);
      chk_eq("r30_s_stb", 64'(s_stb), 64'd0);
      chk_eq("r30_s_adr", 64'(s_adr), 64'd0);
      chk_eq("r30_m1_ack", 64'(m_ack[1]), 64'd0);
      chk_eq("r30_m1_err", 64'(m_err[1]), 64'd0);
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b1;
      slave_mute = 1'b0;
      repeat (4) begin
         @(negedge sys_clk);
         chk_eq("r30_no_stray_ack", 64'(m_ack[1]), 64'd0);
         chk_eq("r30_idle", 64'(s_cyc), 64'd0);
      end

`ifdef WB_ARBITER2_TIMEOUT_EN
      // Silent slave: watchdog errors m0 on the fifth stalled cycle.
      mon_en = 1'b0;
      slave_mute = 1'b1;
      @(posedge sys_clk); #1;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_adr[0] = AW'(32'h0);
      stall = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge sys_clk);
         if (s_cyc && s_stb && !s_ack) stall++;
         if (m_err[0]) break;
      end
      chk_eq("r31_err", 64'(m_err[0]), 64'd1);
      chk_eq("r31_stall_cycles", 64'(stall), 64'd5);
      @(posedge sys_clk); #1;
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
      slave_mute = 1'b0;
      @(negedge sys_clk);
      chk_eq("r31_s_cyc_low", 64'(s_cyc), 64'd0);
      chk_eq("r31_err_pulse", 64'(m_err[0]), 64'd0);
      repeat (2) @(posedge sys_clk);
      mon_en = 1'b1;
`endif

      // Random traffic from both masters against the reference model.
      fork
         rand_master(0, 30);
         rand_master(1, 30);
      join

      repeat (3) @(posedge sys_clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
